// File: rtl/alu_rr_arbiter_if.sv
// alu_rr_arbiter_if: request, ALU and response signals of the shared-ALU arbiter.
interface alu_rr_arbiter_if #(
    parameter int W     = 4,
    parameter int OP_W  = 3,
    parameter int RES_W = 8
);
    // Requester port 0
    logic            req0_valid;
    logic            req0_ready;
    logic [W-1:0]    req0_A;
    logic [W-1:0]    req0_B;
    logic [OP_W-1:0] req0_opcode;

    // Requester port 1
    logic            req1_valid;
    logic            req1_ready;
    logic [W-1:0]    req1_A;
    logic [W-1:0]    req1_B;
    logic [OP_W-1:0] req1_opcode;

    // Shared ALU
    logic [W-1:0]     alu_A;
    logic [W-1:0]     alu_B;
    logic [OP_W-1:0]  alu_opcode;
    logic [RES_W-1:0] alu_result;
    logic             alu_carry;

    // Response and status
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [RES_W-1:0] resp_result;
    logic             resp_carry;
    logic             busy;
    logic [7:0]       ops_done;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_A, req0_B, req0_opcode,
        input  req1_valid, req1_A, req1_B, req1_opcode,
        input  alu_result, alu_carry, resp_ready,
        output req0_ready, req1_ready,
        output alu_A, alu_B, alu_opcode,
        output resp_valid, resp_id, resp_result, resp_carry,
        output busy, ops_done
    );

    // Requester / ALU / consumer side
    modport master (
        output req0_valid, req0_A, req0_B, req0_opcode,
        output req1_valid, req1_A, req1_B, req1_opcode,
        output alu_result, alu_carry, resp_ready,
        input  req0_ready, req1_ready,
        input  alu_A, alu_B, alu_opcode,
        input  resp_valid, resp_id, resp_result, resp_carry,
        input  busy, ops_done
    );
endinterface

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin front end sharing one combinational ALU between
// two requesters. One operation at a time: accept (IDLE), EXEC, RESP.
module alu_rr_arbiter #(
    parameter int W     = 4,
    parameter int OP_W  = 3,
    parameter int RES_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    alu_rr_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_next;

    logic            ptr;          // port favoured when both are valid
    logic            grant_valid;
    logic            grant_id;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;
    logic [OP_W-1:0] sel_op;
    logic            accept;
    logic            resp_done;

    logic [W-1:0]     alu_a_q;
    logic [W-1:0]     alu_b_q;
    logic [OP_W-1:0]  alu_op_q;
    logic [RES_W-1:0] resp_result_q;
    logic             resp_carry_q;
    logic             resp_valid_q;
    logic             resp_id_q;
    logic [7:0]       ops_done_q;

    // Round-robin grant and operand select for the winning port.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant_valid = bus.req0_valid | bus.req1_valid;
        grant_id    = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ptr;
        end else if (bus.req1_valid) begin
            grant_id = 1'b1;
        end
        sel_a  = grant_id ? bus.req1_A      : bus.req0_A;
        sel_b  = grant_id ? bus.req1_B      : bus.req0_B;
        sel_op = grant_id ? bus.req1_opcode : bus.req0_opcode;
    end

    assign accept    = (state == IDLE) && grant_valid;
    assign resp_done = (state == RESP) && bus.resp_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> EXEC on grant, EXEC -> RESP always, RESP -> IDLE on handshake.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid)    state_next = EXEC;
            EXEC:                        state_next = RESP;
            RESP:    if (bus.resp_ready) state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    // Outputs decoded from state: ready only in IDLE for the granted port, held low in reset.
    always_comb begin
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.busy       = (state != IDLE);
        if (!rst && accept) begin
            bus.req0_ready = ~grant_id;
            bus.req1_ready =  grant_id;
        end
    end

    // Datapath: latch granted operands, capture ALU result, count completed responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr           <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= '0;
            resp_result_q <= '0;
            resp_carry_q  <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= 1'b0;
            ops_done_q    <= '0;
        end else begin
            if (accept) begin
                alu_a_q   <= sel_a;
                alu_b_q   <= sel_b;
                alu_op_q  <= sel_op;
                resp_id_q <= grant_id;
                ptr       <= ~grant_id;
            end
            if (state == EXEC) begin
                resp_result_q <= bus.alu_result;
                resp_carry_q  <= bus.alu_carry;
                resp_valid_q  <= 1'b1;
            end
            if (resp_done) begin
                resp_valid_q <= 1'b0;
                ops_done_q   <= ops_done_q + 8'd1;
            end
        end
    end

    assign bus.alu_A       = alu_a_q;
    assign bus.alu_B       = alu_b_q;
    assign bus.alu_opcode  = alu_op_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_id     = resp_id_q;
    assign bus.resp_result = resp_result_q;
    assign bus.resp_carry  = resp_carry_q;
    assign bus.ops_done    = ops_done_q;
endmodule
